// File: rtl/cpu_mem_decode_pipe.sv
// Registered CPU address decoder with a 2-entry skid buffer on the output side.
// Optional OAM DMA engine: define CPU_DECODE_OAM_DMA_EN.
module cpu_mem_decode_pipe #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RAM_SIZE    = 32'h0800,
    parameter int unsigned PPU_BASE    = 32'h2000,
    parameter int unsigned PPU_REGS    = 8,
    parameter int unsigned IO_BASE     = 32'h4000,
    parameter int unsigned EXROM_BASE  = 32'h4020,
    parameter int unsigned EXROM_REMAP = 32'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [7:0]        req_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_sel,
    output logic              out_we,
    output logic [7:0]        out_wdata,
    input  logic [7:0]        dma_rdata,
    input  logic              dma_rdata_valid,
    output logic              dma_active
);
    localparam logic [ADDR_W-1:0] L_RAM_MASK    = ADDR_W'(RAM_SIZE - 1);
    localparam logic [ADDR_W-1:0] L_PPU_MASK    = ADDR_W'(PPU_REGS - 1);
    localparam logic [ADDR_W-1:0] L_PPU_BASE    = ADDR_W'(PPU_BASE);
    localparam logic [ADDR_W-1:0] L_IO_BASE     = ADDR_W'(IO_BASE);
    localparam logic [ADDR_W-1:0] L_EXROM_BASE  = ADDR_W'(EXROM_BASE);
    localparam logic [ADDR_W-1:0] L_EXROM_REMAP = ADDR_W'(EXROM_REMAP);
    localparam int unsigned       ENT_W         = ADDR_W + 11;

    logic [ENT_W-1:0]  r_buf [2];
    logic [1:0]        r_count;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic              r_req_ready;

    logic [ADDR_W-1:0] w_src_addr;
    logic              w_src_we;
    logic [7:0]        w_src_wdata;
    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count_next;
    logic              w_ready_next;
    logic [ADDR_W-1:0] w_dec_addr;
    logic [1:0]        w_dec_sel;

    // Address classification; the ExROM subtraction wraps within ADDR_W bits.
    always_comb begin
        w_dec_sel  = 2'd0;
        w_dec_addr = w_src_addr & L_RAM_MASK;
        if (w_src_addr < L_PPU_BASE) begin
            w_dec_sel  = 2'd0;
            w_dec_addr = w_src_addr & L_RAM_MASK;
        end else if (w_src_addr < L_IO_BASE) begin
            w_dec_sel  = 2'd1;
            w_dec_addr = L_PPU_BASE + (w_src_addr & L_PPU_MASK);
        end else if (w_src_addr < L_EXROM_BASE) begin
            w_dec_sel  = 2'd2;
            w_dec_addr = w_src_addr;
        end else begin
            w_dec_sel  = 2'd0;
            w_dec_addr = w_src_addr - L_EXROM_BASE + L_EXROM_REMAP;
        end
    end

`ifdef CPU_DECODE_OAM_DMA_EN
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic       w_cpu_acc;
    logic       w_dma_kick;
    logic       w_dma_push;

    assign w_cpu_acc  = req_valid & r_req_ready;
    assign w_dma_kick = w_cpu_acc & req_we & (req_addr == L_IO_BASE + ADDR_W'(8'h14));
    assign w_dma_push = ((r_state == S_RD) || (r_state == S_WR)) && (r_count != 2'd2);
    // The kicking write itself is consumed by the engine, never forwarded.
    assign w_push     = (w_cpu_acc & ~w_dma_kick) | w_dma_push;
    assign dma_active = (r_state != S_IDLE);

    always_comb begin
        w_src_addr  = req_addr;
        w_src_we    = req_we;
        w_src_wdata = req_wdata;
        if (r_state == S_RD) begin
            w_src_addr  = ADDR_W'({r_page, r_idx});
            w_src_we    = 1'b0;
            w_src_wdata = 8'h00;
        end else if (r_state == S_WR) begin
            w_src_addr  = L_PPU_BASE + ADDR_W'(4);
            w_src_we    = 1'b1;
            w_src_wdata = r_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_dma_kick) w_state_next = S_RD;
            S_RD:    if (w_dma_push) w_state_next = S_WAIT;
            S_WAIT:  if (dma_rdata_valid) w_state_next = S_WR;
            S_WR:    if (w_dma_push) w_state_next = (r_idx == 8'hFF) ? S_DONE : S_RD;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_dma_kick) begin
                r_page <= req_wdata;
                r_idx  <= 8'h00;
            end
            if ((r_state == S_WAIT) && dma_rdata_valid) r_data <= dma_rdata;
            if ((r_state == S_WR) && w_dma_push) r_idx <= r_idx + 8'h01;
        end
    end

    assign w_ready_next = (w_count_next != 2'd2) && (w_state_next == S_IDLE);
`else
    logic w_unused_dma;

    assign w_unused_dma = ^{dma_rdata, dma_rdata_valid};
    assign w_push       = req_valid & r_req_ready;
    assign w_src_addr   = req_addr;
    assign w_src_we     = req_we;
    assign w_src_wdata  = req_wdata;
    assign dma_active   = 1'b0;
    assign w_ready_next = (w_count_next != 2'd2);
`endif

    assign w_pop        = (r_count != 2'd0) && out_ready;
    assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_count     <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_req_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= {w_dec_addr, w_dec_sel, w_src_we, w_src_wdata};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count     <= w_count_next;
            r_req_ready <= w_ready_next;
        end
    end

    assign req_ready = r_req_ready;
    assign out_valid = (r_count != 2'd0);
    assign {out_addr, out_sel, out_we, out_wdata} = r_buf[r_rd_ptr];
endmodule

// File: tb/tb_cpu_mem_decode_pipe.sv
// Directed bench for cpu_mem_decode_pipe: decode boundaries, skid-buffer ordering, async reset,
// and the OAM DMA sequence when CPU_DECODE_OAM_DMA_EN is defined.
module tb_cpu_mem_decode_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = 16'h0000;
    logic        req_we = 1'b0;
    logic [7:0]  req_wdata = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_addr;
    logic [1:0]  out_sel;
    logic        out_we;
    logic [7:0]  out_wdata;
    logic [7:0]  dma_rdata = 8'h00;
    logic        dma_rdata_valid = 1'b0;
    logic        dma_active;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [26:0] exp_q[$];
    logic [26:0] got_q[$];

    cpu_mem_decode_pipe dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_sel(out_sel), .out_we(out_we), .out_wdata(out_wdata),
        .dma_rdata(dma_rdata), .dma_rdata_valid(dma_rdata_valid), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1; a negedge sample with valid&ready marks the next-edge transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back({out_addr, out_sel, out_we, out_wdata});
`ifdef CPU_DECODE_OAM_DMA_EN
            if (!out_we) begin
                dma_rdata       = out_addr[7:0] ^ 8'hFF;
                dma_rdata_valid = 1'b1;
            end
`endif
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic we, input logic [7:0] d);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: addr %h never accepted, req_ready %b want 1", a, req_ready);
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp += 7;
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (req_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        if (out_addr !== 16'h0)   begin n_fail++; $display("FAIL rst_out_addr: got %h want 0000", out_addr); end
        if (out_sel !== 2'd0)     begin n_fail++; $display("FAIL rst_out_sel: got %0d want 0", out_sel); end
        if (out_we !== 1'b0)      begin n_fail++; $display("FAIL rst_out_we: got %b want 0", out_we); end
        if (out_wdata !== 8'h00)  begin n_fail++; $display("FAIL rst_out_wdata: got %h want 00", out_wdata); end
        if (dma_active !== 1'b0)  begin n_fail++; $display("FAIL rst_dma_active: got %b want 0", dma_active); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_before_edge: got %b want 0", req_ready); end
        wait_cycles(1);
        n_cmp += 2;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after_edge: got %b want 1", req_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_after_edge: got %b want 0", out_valid); end
    endtask

    task automatic test_single_read();
        out_ready = 1'b1;
        send(16'h1803, 1'b0, 8'h00);
        n_cmp += 4;
        if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_addr !== 16'h0003) begin n_fail++; $display("FAIL single_addr: got %h want 0003", out_addr); end
        if (out_sel !== 2'd0)      begin n_fail++; $display("FAIL single_sel: got %0d want 0", out_sel); end
        if (out_we !== 1'b0)       begin n_fail++; $display("FAIL single_we: got %b want 0", out_we); end
        wait_cycles(2);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", out_valid); end
        got_q.delete();
    endtask

    task automatic test_ppu_writes();
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        exp_q.push_back({16'h2000, 2'd1, 1'b1, 8'hA5});
        exp_q.push_back({16'h2001, 2'd1, 1'b1, 8'hA5});
        exp_q.push_back({16'h2007, 2'd1, 1'b1, 8'hA5});
        send(16'h2000, 1'b1, 8'hA5);
        send(16'h2009, 1'b1, 8'hA5);
        send(16'h3FFF, 1'b1, 8'hA5);
        wait_cycles(4);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL ppu_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL ppu_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_boundaries();
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        exp_q.push_back({16'h401F, 2'd2, 1'b0, 8'h00});
        exp_q.push_back({16'h0800, 2'd0, 1'b0, 8'h00});
        exp_q.push_back({16'hC7DF, 2'd0, 1'b0, 8'h00});
        exp_q.push_back({16'h07FF, 2'd0, 1'b1, 8'h3C});
        exp_q.push_back({16'h4000, 2'd2, 1'b0, 8'h00});
        send(16'h401F, 1'b0, 8'h00);
        send(16'h4020, 1'b0, 8'h00);
        send(16'hFFFF, 1'b0, 8'h00);
        send(16'h1FFF, 1'b1, 8'h3C);
        send(16'h4000, 1'b0, 8'h00);
`ifndef CPU_DECODE_OAM_DMA_EN
        exp_q.push_back({16'h4014, 2'd2, 1'b1, 8'h5A});
        send(16'h4014, 1'b1, 8'h5A);
`endif
        wait_cycles(4);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bound_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL bound_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b0;
        exp_q.push_back({16'h0005, 2'd0, 1'b0, 8'h00});
        exp_q.push_back({16'h2003, 2'd1, 1'b1, 8'h11});
        exp_q.push_back({16'h4000, 2'd2, 1'b1, 8'h22});
        send(16'h0005, 1'b0, 8'h00);
        send(16'h2003, 1'b1, 8'h11);
        n_cmp++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", req_ready); end
        req_valid = 1'b1;
        req_addr  = 16'h4000;
        req_we    = 1'b1;
        req_wdata = 8'h22;
        wait_cycles(3);
        req_valid = 1'b0;
        n_cmp += 4;
        if (req_ready !== 1'b0)    begin n_fail++; $display("FAIL b2b_stall_ready: got %b want 0", req_ready); end
        if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL b2b_stall_valid: got %b want 1", out_valid); end
        if (out_addr !== 16'h0005) begin n_fail++; $display("FAIL b2b_stall_hold: got %h want 0005", out_addr); end
        if (got_q.size() !== 0)    begin n_fail++; $display("FAIL b2b_stall_leak: got %0d want 0", got_q.size()); end
        out_ready = 1'b1;
        send(16'h4000, 1'b1, 8'h22);
        wait_cycles(4);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL b2b_item%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        got_q.delete();
        out_ready = 1'b0;
        send(16'h0801, 1'b0, 8'h00);
        send(16'h2345, 1'b1, 8'h77);
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        if (req_ready !== 1'b0)  begin n_fail++; $display("FAIL midrst_ready: got %b want 0", req_ready); end
        if (out_addr !== 16'h0)  begin n_fail++; $display("FAIL midrst_addr: got %h want 0000", out_addr); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(1);
        out_ready = 1'b1;
        send(16'h0000, 1'b0, 8'h00);
        n_cmp += 3;
        if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL postrst_valid: got %b want 1", out_valid); end
        if (out_addr !== 16'h0000) begin n_fail++; $display("FAIL postrst_addr: got %h want 0000", out_addr); end
        if (out_sel !== 2'd0)      begin n_fail++; $display("FAIL postrst_sel: got %0d want 0", out_sel); end
        wait_cycles(2);
        got_q.delete();
    endtask

`ifdef CPU_DECODE_OAM_DMA_EN
    task automatic test_oam_dma();
        bit active_ok;
        int cyc;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({16'h0200 + 16'(i), 2'd0, 1'b0, 8'h00});
            exp_q.push_back({16'h2004, 2'd1, 1'b1, 8'(i) ^ 8'hFF});
        end
        send(16'h4014, 1'b1, 8'h02);
        active_ok = 1'b1;
        cyc = 0;
        while (got_q.size() < 512 && cyc < 5000) begin
            if (dma_active !== 1'b1) active_ok = 1'b0;
            wait_cycles(1);
            cyc++;
        end
        wait_cycles(3);
        n_cmp += 3;
        if (!active_ok)          begin n_fail++; $display("FAIL dma_active_drop: got 0 want 1"); end
        if (cyc >= 5000)         begin n_fail++; $display("FAIL dma_timeout: got %0d items want 512", got_q.size()); end
        if (dma_active !== 1'b0) begin n_fail++; $display("FAIL dma_active_end: got %b want 0", dma_active); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            // Read transactions carry no meaningful data byte.
            logic [26:0] got_m;
            logic [26:0] exp_m;
            got_m = got_q[k][8] ? got_q[k] : {got_q[k][26:8], 8'h00};
            exp_m = exp_q[k];
            n_cmp++;
            if (got_m !== exp_m) begin
                n_fail++;
                $display("FAIL dma_item%0d: got %h want %h", k, got_m, exp_m);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_ppu_writes();
        test_boundaries();
        test_back_to_back();
        test_reset_midstream();
`ifdef CPU_DECODE_OAM_DMA_EN
        test_oam_dma();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
